// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 completer backed by a dual-port word RAM.
// Independent write (aw/w/b) and read (ar/r) engines.
module axi_mem_slave #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h81000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic              w_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI =
    LO + ((ADDR_W+1)'(8) << DEPTH_LOG2);

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_t;

  function automatic logic [2:0] clampSize(
    input logic [2:0] s
  );
    return (s > 3'd3) ? 3'd3 : s;
  endfunction

  function automatic logic wrapBad(
    input logic [1:0] b,
    input logic [7:0] l
  );
    return (b == 2'b10) &&
      !(l == 8'd1 || l == 8'd3 ||
        l == 8'd7 || l == 8'd15);
  endfunction

  function automatic logic inRange(
    input logic [ADDR_W-1:0] a
  );
    return ({1'b0, a} >= LO) && ({1'b0, a} < HI);
  endfunction

  function automatic logic [ADDR_W-1:0] advance(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        l,
    input logic [2:0]        s,
    input logic [1:0]        b
  );
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc = ADDR_W'(1) << s;
    mask = (ADDR_W'(l) + ADDR_W'(1)) << s;
    mask = mask - ADDR_W'(1);
    case (b)
      2'b01: advance = a + inc;
      2'b10: advance = (a & ~mask) | ((a + inc) & mask);
      default: advance = a;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [WORDS];

  // ---------------- write engine ----------------
  wstate_t wState, wNext;
  logic [ID_W-1:0]   wId;
  logic [ADDR_W-1:0] wAddr;
  logic [7:0]        wLen;
  logic [2:0]        wSize;
  logic [1:0]        wBurst;
  logic [8:0]        wBeat;
  logic              wBad;
  logic              wDec;
  logic              awReadyQ, wReadyQ, bValidQ;
  logic [ID_W-1:0]   bIdQ;
  logic [1:0]        bRespQ;
  logic              awReadyD, wReadyD, bValidD;
  logic              awHs, wHs, bHs;
  logic              wInLen, wHit;
  logic              wDecNow, wSlvNow;
  logic [1:0]        bRespD;

  assign aw_ready = awReadyQ;
  assign w_ready  = wReadyQ;
  assign b_valid  = bValidQ;
  assign b_id     = bIdQ;
  assign b_resp   = bRespQ;

  assign awHs = aw_valid && awReadyQ;
  assign wHs  = w_valid && wReadyQ;
  assign bHs  = bValidQ && b_ready;

  assign wInLen = wBeat <= {1'b0, wLen};
  assign wHit = reset && wHs && wInLen &&
    !wBad && inRange(wAddr);

  always_ff @(posedge clock) begin
    if (!reset) wState <= W_IDLE;
    else        wState <= wNext;
  end

  always_comb begin
    wNext = wState;
    unique case (wState)
      W_IDLE:  if (awHs) wNext = W_DATA;
      W_DATA:  if (wHs && w_last) wNext = W_RESP;
      W_RESP:  if (bHs) wNext = W_IDLE;
      default: wNext = W_IDLE;
    endcase
  end

  always_comb begin
    awReadyD = wNext == W_IDLE;
    wReadyD  = wNext == W_DATA;
    bValidD  = wNext == W_RESP;
    wDecNow  = wDec || (wInLen && !inRange(wAddr));
    wSlvNow  = wBad || (wBeat != {1'b0, wLen});
    bRespD   = wDecNow ? 2'b11 :
               (wSlvNow ? 2'b10 : 2'b00);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      awReadyQ <= 1'b0;
      wReadyQ  <= 1'b0;
      bValidQ  <= 1'b0;
      bIdQ     <= '0;
      bRespQ   <= 2'b00;
      wId      <= '0;
      wAddr    <= '0;
      wLen     <= 8'd0;
      wSize    <= 3'd0;
      wBurst   <= 2'b00;
      wBeat    <= 9'd0;
      wBad     <= 1'b0;
      wDec     <= 1'b0;
    end else begin
      awReadyQ <= awReadyD;
      wReadyQ  <= wReadyD;
      bValidQ  <= bValidD;
      if (awHs) begin
        wId    <= aw_id;
        wAddr  <= aw_addr;
        wLen   <= aw_len;
        wSize  <= clampSize(aw_size);
        wBurst <= aw_burst;
        wBeat  <= 9'd0;
        wBad   <= wrapBad(aw_burst, aw_len);
        wDec   <= 1'b0;
      end else if (wHs) begin
        if (!wBad)
          wAddr <= advance(wAddr, wLen, wSize, wBurst);
        if (wBeat != 9'h1FF)
          wBeat <= wBeat + 9'd1;
        wDec <= wDecNow;
        if (w_last) begin
          bIdQ   <= wId;
          bRespQ <= bRespD;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wHit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i])
          mem[wAddr[DEPTH_LOG2+2:3]][i*8 +: 8] <=
            w_data[i*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t rState, rNext;
  logic [ID_W-1:0]   rId;
  logic [ADDR_W-1:0] rAddr;
  logic [7:0]        rLen;
  logic [2:0]        rSize;
  logic [1:0]        rBurst;
  logic [7:0]        rBeat;
  logic              rBad;
  logic              arReadyQ, rValidQ, rLastQ;
  logic [ID_W-1:0]   rIdQ;
  logic [DATA_W-1:0] rDataQ;
  logic [1:0]        rRespQ;
  logic              arReadyD, rValidD, rFetch;
  logic              arHs, rHs;

  assign ar_ready = arReadyQ;
  assign r_valid  = rValidQ;
  assign r_id     = rIdQ;
  assign r_data   = rDataQ;
  assign r_resp   = rRespQ;
  assign r_last   = rLastQ;

  assign arHs = ar_valid && arReadyQ;
  assign rHs  = rValidQ && r_ready;

  always_ff @(posedge clock) begin
    if (!reset) rState <= R_IDLE;
    else        rState <= rNext;
  end

  always_comb begin
    rNext = rState;
    unique case (rState)
      R_IDLE:  if (arHs) rNext = R_DATA;
      R_DATA:  if (rHs && rLastQ) rNext = R_IDLE;
      default: rNext = R_IDLE;
    endcase
  end

  // Fetch fills an empty output register or replaces a consumed beat.
  always_comb begin
    arReadyD = rNext == R_IDLE;
    rFetch   = (rState == R_DATA) &&
      (!rValidQ || (r_ready && !rLastQ));
    rValidD  = rFetch || (rValidQ && !r_ready);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      arReadyQ <= 1'b0;
      rValidQ  <= 1'b0;
      rLastQ   <= 1'b0;
      rIdQ     <= '0;
      rDataQ   <= '0;
      rRespQ   <= 2'b00;
      rId      <= '0;
      rAddr    <= '0;
      rLen     <= 8'd0;
      rSize    <= 3'd0;
      rBurst   <= 2'b00;
      rBeat    <= 8'd0;
      rBad     <= 1'b0;
    end else begin
      arReadyQ <= arReadyD;
      rValidQ  <= rValidD;
      if (arHs) begin
        rId    <= ar_id;
        rAddr  <= ar_addr;
        rLen   <= ar_len;
        rSize  <= clampSize(ar_size);
        rBurst <= ar_burst;
        rBeat  <= 8'd0;
        rBad   <= wrapBad(ar_burst, ar_len);
      end else if (rFetch) begin
        rIdQ   <= rId;
        rLastQ <= rBeat == rLen;
        if (!inRange(rAddr)) begin
          rDataQ <= '0;
          rRespQ <= 2'b11;
        end else if (rBad) begin
          rDataQ <= '0;
          rRespQ <= 2'b10;
        end else begin
          rDataQ <= mem[rAddr[DEPTH_LOG2+2:3]];
          rRespQ <= 2'b00;
        end
        if (!rBad)
          rAddr <= advance(rAddr, rLen, rSize, rBurst);
        rBeat <= rBeat + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed vectors and burst sequences
// for the AXI4 memory completer.
module tb_axi_mem_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int nCmp = 0;
  int nBad = 0;

  logic [63:0] gotData [256];
  logic [1:0]  gotResp [256];
  logic        gotLast [256];

  always #5 clock = ~clock;

  axi_mem_slave dut (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_strb(w_strb),
    .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nCmp++;
    nBad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  task automatic writeBurst(
    input  logic [3:0]  id,
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    input  int          nBeats,
    input  logic [63:0] base,
    input  logic [7:0]  strb,
    input  bit          waitB,
    output logic [1:0]  resp
  );
    int cyc;
    aw_id = id;
    aw_addr = addr;
    aw_len = len;
    aw_size = size;
    aw_burst = burst;
    aw_valid = 1'b1;
    cyc = 0;
    while (!aw_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) timeout("aw_wait");
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      w_valid = 1'b1;
      w_data = base + 64'(i);
      w_strb = strb;
      w_last = (i == nBeats - 1);
      cyc = 0;
      while (!w_ready && cyc < 50) begin
        tick();
        cyc++;
      end
      if (cyc >= 50) timeout("w_wait");
      tick();
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    check("b_valid_after_last", 64'(b_valid), 64'd1);
    check("b_id", 64'(b_id), 64'(id));
    resp = b_resp;
    if (waitB) begin
      b_ready = 1'b1;
      tick();
      check("b_valid_clear", 64'(b_valid), 64'd0);
    end
  endtask

  task automatic readBurst(
    input  logic [3:0]  id,
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    input  logic [3:0]  pat,
    output int          nGot,
    output int          firstLat
  );
    int cyc;
    logic stalled;
    logic [63:0] hd;
    logic hl;
    ar_id = id;
    ar_addr = addr;
    ar_len = len;
    ar_size = size;
    ar_burst = burst;
    ar_valid = 1'b1;
    cyc = 0;
    while (!ar_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) timeout("ar_wait");
    tick();
    ar_valid = 1'b0;
    nGot = 0;
    firstLat = -1;
    cyc = 0;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (nGot < int'(len) + 1 && cyc < 200) begin
      r_ready = pat[cyc[1:0]];
      if (r_valid && firstLat < 0) firstLat = cyc;
      if (stalled) begin
        check("stall_valid", 64'(r_valid), 64'd1);
        check("stall_data", r_data, hd);
        check("stall_last", 64'(r_last), 64'(hl));
      end
      if (r_valid && r_ready) begin
        gotData[nGot] = r_data;
        gotResp[nGot] = r_resp;
        gotLast[nGot] = r_last;
        check("r_id", 64'(r_id), 64'(id));
        nGot++;
        stalled = 1'b0;
      end else if (r_valid) begin
        stalled = 1'b1;
        hd = r_data;
        hl = r_last;
      end
      tick();
      cyc++;
    end
    r_ready = 1'b1;
    if (cyc >= 200) timeout("r_beats");
    check("r_valid_after_last", 64'(r_valid), 64'd0);
    check("ar_ready_after_last", 64'(ar_ready), 64'd1);
  endtask

  typedef struct {
    logic        doWr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  expB;
    logic [63:0] expR;
    logic [1:0]  expRresp;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [1:0] resp;
    int n;
    int lat;
    int cyc;
    int got;

    vt[0] = '{1'b1, 32'h81000010, 64'hFFFFFFFFFFFFFFFF,
              8'hFF, 2'd0, 64'hFFFFFFFFFFFFFFFF, 2'd0};
    vt[1] = '{1'b1, 32'h81000010, 64'h0,
              8'h0F, 2'd0, 64'hFFFFFFFF00000000, 2'd0};
    vt[2] = '{1'b1, 32'h81000020, 64'h1122334455667788,
              8'hFF, 2'd0, 64'h1122334455667788, 2'd0};
    vt[3] = '{1'b1, 32'h81000020, 64'hAAAAAAAAAAAAAAAA,
              8'hA5, 2'd0, 64'hAA22AA4455AA77AA, 2'd0};
    vt[4] = '{1'b1, 32'h81001FF8, 64'hDEADBEEF01234567,
              8'hFF, 2'd0, 64'hDEADBEEF01234567, 2'd0};
    vt[5] = '{1'b1, 32'h81002000, 64'h5555,
              8'hFF, 2'd3, 64'h0, 2'd3};
    vt[6] = '{1'b1, 32'h80FFFFF8, 64'h6666,
              8'hFF, 2'd3, 64'h0, 2'd3};
    vt[7] = '{1'b0, 32'h81000000, 64'h0,
              8'h00, 2'd0, 64'h0, 2'd0};
    vt[8] = '{1'b0, 32'h81001FF8, 64'h0,
              8'h00, 2'd0, 64'hDEADBEEF01234567, 2'd0};
    vt[9] = '{1'b0, 32'h81000018, 64'h0,
              8'h00, 2'd0, 64'h3, 2'd0};

    reset = 1'b0;
    aw_valid = 1'b0; aw_id = '0; aw_addr = '0;
    aw_len = '0; aw_size = '0; aw_burst = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0;
    w_last = 1'b0; b_ready = 1'b1;
    ar_valid = 1'b0; ar_id = '0; ar_addr = '0;
    ar_len = '0; ar_size = '0; ar_burst = '0;
    r_ready = 1'b1;

    // reset state
    tick(); tick(); tick();
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    reset = 1'b1;
    tick();
    check("rel_aw_ready", 64'(aw_ready), 64'd1);
    check("rel_ar_ready", 64'(ar_ready), 64'd1);
    check("rel_w_ready", 64'(w_ready), 64'd0);

    // INCR write/read with latency check
    writeBurst(4'h5, 32'h81000000, 8'd3, 3'd3, 2'b01,
               4, 64'd0, 8'hFF, 1'b1, resp);
    check("t1_bresp", 64'(resp), 64'd0);
    readBurst(4'h9, 32'h81000000, 8'd3, 3'd3, 2'b01,
              4'hF, n, lat);
    check("t1_first_rvalid", 64'(lat), 64'd1);
    check("t1_nbeats", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_data%0d", i), gotData[i], 64'(i));
      check($sformatf("t1_last%0d", i),
            64'(gotLast[i]), 64'(i == 3));
      check($sformatf("t1_resp%0d", i),
            64'(gotResp[i]), 64'd0);
    end

    // single-beat vector table
    foreach (vt[i]) begin
      if (vt[i].doWr) begin
        writeBurst(4'h1, vt[i].addr, 8'd0, 3'd3, 2'b01,
                   1, vt[i].data, vt[i].strb, 1'b1, resp);
        check($sformatf("vec%0d_bresp", i),
              64'(resp), 64'(vt[i].expB));
      end
      readBurst(4'h2, vt[i].addr, 8'd0, 3'd3, 2'b01,
                4'hF, n, lat);
      check($sformatf("vec%0d_rdata", i),
            gotData[0], vt[i].expR);
      check($sformatf("vec%0d_rresp", i),
            64'(gotResp[0]), 64'(vt[i].expRresp));
      check($sformatf("vec%0d_rlast", i),
            64'(gotLast[0]), 64'd1);
    end

    // read backpressure 1,0,0,1 on len=7
    writeBurst(4'h3, 32'h81000100, 8'd7, 3'd3, 2'b01,
               8, 64'h100, 8'hFF, 1'b1, resp);
    check("t3_bresp", 64'(resp), 64'd0);
    readBurst(4'h4, 32'h81000100, 8'd7, 3'd3, 2'b01,
              4'b1001, n, lat);
    check("t3_nbeats", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_data%0d", i),
            gotData[i], 64'h100 + 64'(i));
      check($sformatf("t3_last%0d", i),
            64'(gotLast[i]), 64'(i == 7));
    end

    // decode errors straddling the base address
    writeBurst(4'h6, 32'h80FFFFF8, 8'd1, 3'd3, 2'b01,
               2, 64'h77, 8'hFF, 1'b1, resp);
    check("t4_bresp", 64'(resp), 64'd3);
    readBurst(4'h7, 32'h80000000, 8'd0, 3'd3, 2'b01,
              4'hF, n, lat);
    check("t4_oor_data", gotData[0], 64'd0);
    check("t4_oor_resp", 64'(gotResp[0]), 64'd3);
    check("t4_oor_last", 64'(gotLast[0]), 64'd1);
    readBurst(4'h7, 32'h80FFFFF8, 8'd1, 3'd3, 2'b01,
              4'hF, n, lat);
    check("t4_mix_resp0", 64'(gotResp[0]), 64'd3);
    check("t4_mix_data1", gotData[1], 64'h78);
    check("t4_mix_resp1", 64'(gotResp[1]), 64'd0);

    // WRAP bursts and malformed bursts
    writeBurst(4'h8, 32'h81000018, 8'd3, 3'd3, 2'b10,
               4, 64'hA0, 8'hFF, 1'b1, resp);
    check("t5_wrap_bresp", 64'(resp), 64'd0);
    readBurst(4'h8, 32'h81000000, 8'd3, 3'd3, 2'b01,
              4'hF, n, lat);
    check("t5_w00", gotData[0], 64'hA1);
    check("t5_w08", gotData[1], 64'hA2);
    check("t5_w10", gotData[2], 64'hA3);
    check("t5_w18", gotData[3], 64'hA0);
    readBurst(4'h8, 32'h81000018, 8'd3, 3'd3, 2'b10,
              4'hF, n, lat);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_wrap_rd%0d", i),
            gotData[i], 64'hA0 + 64'(i));
    writeBurst(4'h9, 32'h81000000, 8'd2, 3'd3, 2'b10,
               3, 64'hB0, 8'hFF, 1'b1, resp);
    check("t5_badwrap_bresp", 64'(resp), 64'd2);
    readBurst(4'h9, 32'h81000000, 8'd3, 3'd3, 2'b01,
              4'hF, n, lat);
    for (int i = 0; i < 3; i++)
      check($sformatf("t5_unchanged%0d", i),
            gotData[i], 64'hA1 + 64'(i));
    writeBurst(4'hA, 32'h81000040, 8'd3, 3'd3, 2'b01,
               2, 64'hC0, 8'hFF, 1'b1, resp);
    check("t5_short_bresp", 64'(resp), 64'd2);

    // reset mid-read with a pending write response
    b_ready = 1'b0;
    writeBurst(4'hB, 32'h81000200, 8'd0, 3'd3, 2'b01,
               1, 64'h6666, 8'hFF, 1'b0, resp);
    ar_id = 4'hC;
    ar_addr = 32'h81000100;
    ar_len = 8'd7;
    ar_size = 3'd3;
    ar_burst = 2'b01;
    ar_valid = 1'b1;
    r_ready = 1'b1;
    cyc = 0;
    while (!ar_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) timeout("t6_ar_wait");
    tick();
    ar_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 50) begin
      if (r_valid) got++;
      tick();
      cyc++;
    end
    if (cyc >= 50) timeout("t6_beats");
    check("t6_beat2_data", r_data, 64'h102);
    check("t6_b_pending", 64'(b_valid), 64'd1);
    reset = 1'b0;
    tick();
    check("t6_rst_b_valid", 64'(b_valid), 64'd0);
    check("t6_rst_r_valid", 64'(r_valid), 64'd0);
    check("t6_rst_r_last", 64'(r_last), 64'd0);
    check("t6_rst_r_data", r_data, 64'd0);
    check("t6_rst_aw_ready", 64'(aw_ready), 64'd0);
    reset = 1'b1;
    b_ready = 1'b1;
    tick();
    check("t6_rel_aw_ready", 64'(aw_ready), 64'd1);
    check("t6_rel_ar_ready", 64'(ar_ready), 64'd1);
    readBurst(4'hD, 32'h81000200, 8'd0, 3'd3, 2'b01,
              4'hF, n, lat);
    check("t6_keep_200", gotData[0], 64'h6666);
    readBurst(4'hD, 32'h81000100, 8'd0, 3'd3, 2'b01,
              4'hF, n, lat);
    check("t6_keep_100", gotData[0], 64'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
